ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the execute stage (MUL, MULHU, DIVU, REMU).
// Multiply is radix-2 shift-add, divide is restoring, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: MUL finishes as soon as the remaining multiplier
// bits are all zero.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_e,
  input  logic [1:0]      op_e,
  input  logic [XLEN-1:0] srca_e,
  input  logic [XLEN-1:0] srcb_e,
  input  logic [4:0]      rd_e,
  input  logic            flush_e,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Trial subtract of the shifted partial remainder; the top bit is the borrow.
  logic [XLEN+1:0]   trial;
  assign trial = {rem_q, quo_q[XLEN-1]} - {2'b00, divisor_q};

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (start_e && !flush_e) begin
          op_d      = op_e;
          rd_d      = rd_e;
          cnt_d     = '0;
          prod_d    = '0;
          mcand_d   = {{XLEN{1'b0}}, srca_e};
          mplier_d  = srcb_e;
          rem_d     = '0;
          quo_d     = srca_e;
          divisor_d = srcb_e;
          state_d   = op_e[1] ? StDiv : StMul;
        end
      end
      StMul: begin
        if (flush_e) begin
          state_d = StIdle;
        end else if (cnt_q == CW'(XLEN)) begin
          state_d  = StDone;
          result_d = op_q[0] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        end else begin
          prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
          // Multiplicand is pre-shifted, so the product is already aligned.
          if (mplier_d == '0) cnt_d = CW'(XLEN);
`endif
        end
      end
      StDiv: begin
        if (flush_e) begin
          state_d = StIdle;
        end else if (cnt_q == CW'(XLEN)) begin
          state_d  = StDone;
          result_d = op_q[0] ? rem_q[XLEN-1:0] : quo_q;
        end else if (cnt_q == '0 && divisor_q == '0) begin
          // Divide by zero: quotient all ones, remainder is the dividend.
          quo_d = '1;
          rem_d = {1'b0, quo_q};
          cnt_d = CW'(XLEN);
        end else begin
          if (!trial[XLEN+1]) begin
            rem_d = trial[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
    end
  end

  // Outputs: stall covers the accepting cycle, busy/done decode the registered state.
  always_comb begin
    stall_o  = (state_q == StIdle && start_e && !flush_e) ||
               state_q == StMul || state_q == StDiv;
    busy_o   = state_q == StMul || state_q == StDiv;
    done_o   = state_q == StDone;
    result_o = result_q;
    rd_o     = rd_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_e;
  logic [1:0]  op_e;
  logic [31:0] srca_e;
  logic [31:0] srcb_e;
  logic [4:0]  rd_e;
  logic        flush_e;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start_e (start_e),
    .op_e    (op_e),
    .srca_e  (srca_e),
    .srcb_e  (srcb_e),
    .rd_e    (rd_e),
    .flush_e (flush_e),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o),
    .rd_o    (rd_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected edges from accept to done for a MUL with multiplier b.
  function automatic int mul_lat(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    int h;
    h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return h + 2;
`else
    return 33 + 0 * int'(b[0]);
`endif
  endfunction

  // Issue one op, wait (bounded) for done, check latency/stall/result/rd.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                        input logic [31:0] exp_res);
    int  lat;
    int  stalls;
    bit  got;
    @(negedge clk);
    start_e = 1'b1; op_e = op; srca_e = a; srcb_e = b; rd_e = rd;
    #1;
    check_val({tag, "_stall_start"}, 32'(stall_o), 32'd1);
    @(posedge clk);
    #1;
    start_e = 1'b0;
    lat = 0; stalls = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (stall_o) stalls++;
      if (done_o) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check_val({tag, "_done_seen"}, 32'(got), 32'd1);
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
    check_val({tag, "_result"}, result_o, exp_res);
    check_val({tag, "_rd"}, 32'(rd_o), 32'(rd));
    check_val({tag, "_busy_in_done"}, 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    check_val({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int dones;
    reset_n = 1'b0; start_e = 1'b0; op_e = 2'b00; srca_e = '0; srcb_e = '0;
    rd_e = '0; flush_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_done", 32'(done_o), 32'd0);
    check_val("rst_result", result_o, 32'd0);
    check_val("rst_rd", 32'(rd_o), 32'd0);
    check_val("rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 5'h09, mul_lat(32'd6), 32'h0000_002A);
    run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h01, mul_lat(32'hFFFF_FFFF),
           32'hFFFF_FFFE);
    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, mul_lat(32'hFFFF_FFFF),
           32'h0000_0001);
    run_op("divu100_7", 2'b10, 32'd100, 32'd7, 5'h03, 33, 32'h0000_000E);
    run_op("remu100_7", 2'b11, 32'd100, 32'd7, 5'h04, 33, 32'h0000_0002);
    run_op("divu_by0", 2'b10, 32'h1234_5678, 32'd0, 5'h05, 2, 32'hFFFF_FFFF);
    run_op("remu_by0", 2'b11, 32'd5, 32'd0, 5'h06, 2, 32'h0000_0005);

    // Flush and start together in IDLE: flush wins.
    @(negedge clk);
    start_e = 1'b1; flush_e = 1'b1; op_e = 2'b00; srca_e = 32'd2; srcb_e = 32'd2;
    #1;
    check_val("flush_start_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    start_e = 1'b0; flush_e = 1'b0;
    check_val("flush_start_busy", 32'(busy_o), 32'd0);

    // Flush a DIVU in flight at iteration 10.
    @(negedge clk);
    start_e = 1'b1; op_e = 2'b10; srca_e = 32'd100; srcb_e = 32'd7; rd_e = 5'h07;
    @(posedge clk);
    #1;
    start_e = 1'b0;
    dones = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    check_val("flush_busy_before", 32'(busy_o), 32'd1);
    @(negedge clk);
    flush_e = 1'b1;
    @(posedge clk);
    #1;
    flush_e = 1'b0;
    check_val("flush_busy_after", 32'(busy_o), 32'd0);
    check_val("flush_stall_after", 32'(stall_o), 32'd0);
    if (done_o) dones++;
    check_val("flush_no_done", 32'(dones), 32'd0);
    run_op("mul3x3", 2'b00, 32'd3, 32'd3, 5'h08, mul_lat(32'd3), 32'h0000_0009);

    // Reset in the middle of a MUL at iteration 20.
    @(negedge clk);
    start_e = 1'b1; op_e = 2'b00; srca_e = 32'h0000_FFFF; srcb_e = 32'hFFFF_FFFF;
    rd_e = 5'h1F;
    @(posedge clk);
    #1;
    start_e = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_busy", 32'(busy_o), 32'd0);
    check_val("midrst_done", 32'(done_o), 32'd0);
    check_val("midrst_result", result_o, 32'd0);
    check_val("midrst_rd", 32'(rd_o), 32'd0);
    check_val("midrst_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) dones++;
    end
    check_val("midrst_idle", 32'(dones), 32'd0);

    run_op("mul_ffff_x1", 2'b00, 32'h0000_FFFF, 32'd1, 5'h0A, mul_lat(32'd1), 32'h0000_FFFF);
    run_op("mul_x0", 2'b00, 32'h0000_1234, 32'd0, 5'h0B, mul_lat(32'd0), 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
